// File: rtl/frame_streamer.sv
// Raster pixel-stream transmitter: reads a WIDTH x HEIGHT RGB888 frame and emits it with h/v blanking.
// Define STREAM_TESTPAT_EN to source pixels from an internal x/y pattern generator instead of memory.
module frame_streamer #(
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 240,
  parameter int HBLANK = 16,
  parameter int VBLANK = 64,
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              cont,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [23:0]       mem_rdata,
  output logic [7:0]        out_r,
  output logic [7:0]        out_g,
  output logic [7:0]        out_b,
  output logic              out_valid,
  output logic              out_sof,
  output logic              out_eol,
  output logic              busy,
  output logic              frame_done
);

  localparam int XW = $clog2(WIDTH + 1);
  localparam int YW = $clog2(HEIGHT + 1);
  localparam int CW = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_HBLANK = 2'd2,
    ST_VBLANK = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic s1_valid_q, s1_sof_q, s1_eol_q, s1_done_q;
  logic out_valid_q, out_sof_q, out_eol_q, out_done_q;
  logic [23:0] out_pix_q;
  logic [23:0] pix_in_s;

  logic issue_s, line_end_s, last_line_s, busy_s;

  assign issue_s     = (state_q == ST_ACTIVE);
  assign line_end_s  = (x_q == XW'(WIDTH - 1));
  assign last_line_s = (y_q == YW'(HEIGHT - 1));
  assign busy_s      = (state_q != ST_IDLE) | s1_valid_q | out_valid_q;

  // Next-state and raster counter update
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start && !busy_s) state_d = ST_ACTIVE;
        else                  state_d = ST_IDLE;
      end
      ST_ACTIVE: begin
        addr_d = addr_q + ADDR_W'(1);
        x_d    = x_q + XW'(1);
        if (line_end_s) begin
          x_d   = '0;
          cnt_d = '0;
          if (!last_line_s) begin
            y_d = y_q + YW'(1);
            if (HBLANK == 0) state_d = ST_ACTIVE;
            else             state_d = ST_HBLANK;
          end else begin
            // Frame counters are cleared here so a continuous restart begins at address 0
            y_d    = '0;
            addr_d = '0;
            if (VBLANK != 0) state_d = ST_VBLANK;
            else if (cont)   state_d = ST_ACTIVE;
            else             state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_ACTIVE;
        end
      end
      ST_HBLANK: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(HBLANK - 1)) begin
          cnt_d   = '0;
          state_d = ST_ACTIVE;
        end else begin
          state_d = ST_HBLANK;
        end
      end
      ST_VBLANK: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(VBLANK - 1)) begin
          cnt_d = '0;
          if (cont) state_d = ST_ACTIVE;
          else      state_d = ST_IDLE;
        end else begin
          state_d = ST_VBLANK;
        end
      end
      default: begin
        state_d = ST_IDLE;
        x_d     = '0;
        y_d     = '0;
        addr_d  = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // State and raster counter registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef STREAM_TESTPAT_EN
  logic [23:0] s1_pix_q;
  logic [7:0]  pat_x_s, pat_y_s;

  assign pat_x_s   = 8'(x_q);
  assign pat_y_s   = 8'(y_q);
  assign pix_in_s  = s1_pix_q;
  assign mem_rd_en = 1'b0;
  assign mem_addr  = '0;

  // Pattern pixel captured at issue so it lines up with the memory-mode read latency
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_pix_q <= 24'd0;
    end else if (issue_s) begin
      s1_pix_q <= {pat_x_s, pat_y_s, 8'(pat_x_s + pat_y_s)};
    end else begin
      s1_pix_q <= 24'd0;
    end
  end
`else
  assign pix_in_s  = mem_rdata;
  assign mem_rd_en = issue_s;
  assign mem_addr  = addr_q;
`endif

  // Two-stage read pipeline carrying the frame flags alongside the pixel
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_sof_q    <= 1'b0;
      s1_eol_q    <= 1'b0;
      s1_done_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_sof_q   <= 1'b0;
      out_eol_q   <= 1'b0;
      out_done_q  <= 1'b0;
      out_pix_q   <= 24'd0;
    end else begin
      s1_valid_q  <= issue_s;
      s1_sof_q    <= issue_s & (x_q == '0) & (y_q == '0);
      s1_eol_q    <= issue_s & line_end_s;
      s1_done_q   <= issue_s & line_end_s & last_line_s;
      out_valid_q <= s1_valid_q;
      out_sof_q   <= s1_sof_q;
      out_eol_q   <= s1_eol_q;
      out_done_q  <= s1_done_q;
      out_pix_q   <= s1_valid_q ? pix_in_s : 24'd0;
    end
  end

  assign out_r      = out_pix_q[23:16];
  assign out_g      = out_pix_q[15:8];
  assign out_b      = out_pix_q[7:0];
  assign out_valid  = out_valid_q;
  assign out_sof    = out_sof_q;
  assign out_eol    = out_eol_q;
  assign frame_done = out_done_q;
  assign busy       = busy_s;

endmodule

// File: tb/tb_frame_streamer.sv
// Directed bench for frame_streamer: WIDTH=4, HEIGHT=2, one instance with blanking (2/3), one gapless (0/0).
module tb_frame_streamer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_a = 1'b0, cont_a = 1'b0, start_b = 1'b0, cont_b = 1'b0;

  logic        rd_a, rd_b;
  logic [16:0] addr_a, addr_b;
  logic [23:0] rdata_a = 24'd0, rdata_b = 24'd0;
  logic [7:0]  r_a, g_a, b_a, r_b, g_b, b_b;
  logic        v_a, sof_a, eol_a, busy_a, done_a;
  logic        v_b, sof_b, eol_b, busy_b, done_b;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  // Pixel memory model: word equals its address, one-cycle read latency
  always @(posedge clk) begin
    if (rd_a) rdata_a <= 24'(addr_a);
    if (rd_b) rdata_b <= 24'(addr_b);
  end

  frame_streamer #(.WIDTH(4), .HEIGHT(2), .HBLANK(2), .VBLANK(3), .ADDR_W(17)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .cont(cont_a),
    .mem_rd_en(rd_a), .mem_addr(addr_a), .mem_rdata(rdata_a),
    .out_r(r_a), .out_g(g_a), .out_b(b_a), .out_valid(v_a), .out_sof(sof_a),
    .out_eol(eol_a), .busy(busy_a), .frame_done(done_a)
  );

  frame_streamer #(.WIDTH(4), .HEIGHT(2), .HBLANK(0), .VBLANK(0), .ADDR_W(17)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .cont(cont_b),
    .mem_rd_en(rd_b), .mem_addr(addr_b), .mem_rdata(rdata_b),
    .out_r(r_b), .out_g(g_b), .out_b(b_b), .out_valid(v_b), .out_sof(sof_b),
    .out_eol(eol_b), .busy(busy_b), .frame_done(done_b)
  );

  function automatic logic [46:0] pack(logic rd, logic [16:0] a, logic v, logic s, logic e,
                                       logic d, logic b, logic [23:0] px);
    return {rd, a, v, s, e, d, b, px};
  endfunction

  function automatic logic [23:0] pix_of(int p);
`ifdef STREAM_TESTPAT_EN
    int x = p % 4;
    int y = p / 4;
    return {8'(x), 8'(y), 8'(x + y)};
`else
    return 24'(p);
`endif
  endfunction

  // Memory-mode read slots of one frame, cycle l counted from the start cycle (0)
  function automatic logic frame_slot(int l);
    return (l >= 1 && l <= 4) || (l >= 7 && l <= 10);
  endfunction

  function automatic logic [46:0] frame_exp(int l);
    logic rd = 1'b0;
    logic [16:0] a = 17'd0;
    logic v = 1'b0;
    int p = 0;
    if (l >= 1 && l <= 4) begin rd = 1'b1; a = 17'(l - 1); end
    else if (l >= 7 && l <= 10) begin rd = 1'b1; a = 17'(l - 3); end
    if (l >= 3 && l <= 6) begin v = 1'b1; p = l - 3; end
    else if (l >= 9 && l <= 12) begin v = 1'b1; p = l - 5; end
`ifdef STREAM_TESTPAT_EN
    rd = 1'b0;
    a = 17'd0;
`endif
    return pack(rd, a, v, l == 3, l == 6 || l == 12, l == 12, l >= 1 && l <= 13,
                v ? pix_of(p) : 24'd0);
  endfunction

  // Gapless continuous run of three frames, cont dropped before the third frame's decision
  function automatic logic [46:0] gapless_exp(int c);
    logic rd = 1'b0;
    logic [16:0] a = 17'd0;
    logic v = 1'b0;
    int p = 0;
    if (c >= 1 && c <= 24) begin rd = 1'b1; a = 17'((c - 1) % 8); end
    if (c >= 3 && c <= 26) begin v = 1'b1; p = (c - 3) % 8; end
`ifdef STREAM_TESTPAT_EN
    rd = 1'b0;
    a = 17'd0;
`endif
    return pack(rd, a, v, v && p == 0, v && (p % 4) == 3, v && p == 7, c >= 1 && c <= 26,
                v ? pix_of(p) : 24'd0);
  endfunction

  function automatic logic [46:0] obs_a(logic slot);
    return pack(rd_a, slot ? addr_a : 17'd0, v_a, sof_a, eol_a, done_a, busy_a, {r_a, g_a, b_a});
  endfunction

  function automatic logic [46:0] obs_b(logic slot);
    return pack(rd_b, slot ? addr_b : 17'd0, v_b, sof_b, eol_b, done_b, busy_b, {r_b, g_b, b_b});
  endfunction

  task automatic test_reset();
    logic [46:0] got;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    got = obs_a(1'b1);
    total++;
    if (got !== 47'd0) begin
      bad++;
      $display("FAIL reset_a got=%h exp=%h", got, 47'd0);
    end
    got = obs_b(1'b1);
    total++;
    if (got !== 47'd0) begin
      bad++;
      $display("FAIL reset_b got=%h exp=%h", got, 47'd0);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_frame();
    logic [46:0] got, exp;
    start_a = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      got = obs_a(frame_slot(c));
      exp = frame_exp(c);
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL single_frame cyc=%0d got=%h exp=%h", c, got, exp);
      end
      start_a = 1'b0;
    end
  endtask

  task automatic test_continuous();
    logic [46:0] got, exp;
    int l;
    cont_a = 1'b1;
    start_a = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      l = (c <= 13) ? c : ((c <= 26) ? c - 13 : 0);
      got = obs_a(frame_slot(l));
      exp = frame_exp(l);
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL continuous cyc=%0d got=%h exp=%h", c, got, exp);
      end
      start_a = 1'b0;
      if (c == 20) cont_a = 1'b0;
    end
  endtask

  task automatic test_ignore_start();
    logic [46:0] got, exp;
    start_a = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      got = obs_a(frame_slot(c));
      exp = frame_exp(c);
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL ignore_start cyc=%0d got=%h exp=%h", c, got, exp);
      end
      start_a = (c == 2 || c == 5);
    end
  endtask

  task automatic test_back_to_back();
    logic [46:0] got, exp;
    cont_b = 1'b1;
    start_b = 1'b1;
    for (int c = 1; c <= 28; c++) begin
      @(negedge clk);
      got = obs_b(c >= 1 && c <= 24);
      exp = gapless_exp(c);
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL back_to_back cyc=%0d got=%h exp=%h", c, got, exp);
      end
      start_b = 1'b0;
      if (c == 20) cont_b = 1'b0;
    end
  endtask

  task automatic test_midframe_reset();
    logic [46:0] got, exp;
    start_a = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      got = obs_a(frame_slot(c));
      exp = frame_exp(c);
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL pre_reset cyc=%0d got=%h exp=%h", c, got, exp);
      end
      start_a = 1'b0;
    end
    rst_n = 1'b0;
    @(negedge clk);
    got = obs_a(1'b1);
    total++;
    if (got !== 47'd0) begin
      bad++;
      $display("FAIL midframe_reset got=%h exp=%h", got, 47'd0);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    start_a = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      got = obs_a(frame_slot(c));
      exp = frame_exp(c);
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL restart cyc=%0d got=%h exp=%h", c, got, exp);
      end
      start_a = 1'b0;
    end
    repeat (10) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single_frame();
    repeat (2) @(negedge clk);
    test_continuous();
    repeat (2) @(negedge clk);
    test_ignore_start();
    repeat (2) @(negedge clk);
    test_back_to_back();
    repeat (2) @(negedge clk);
    test_midframe_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
